rand_noise_gen: RTL and testbench

- Multi-channel pseudo-random noise source for the generator datapath; next generation of the single-channel bit-LFSR generator.
- Per channel: reseedable 64-bit XNOR LFSR stepped DW bits per clock, selectable distribution (uniform / approx-Gaussian / DC), amplitude scaling, offset, saturation, valid flag.
- Sits in front of the DAC output mux; one instance serves all channels.

---
 rtl/rand_pkg.sv | 51 +++++
 rtl/rand_noise_ch.sv | 118 +++++++++++
 rtl/rand_noise_gen.sv | 45 ++++
 tb/tb_rand_noise_gen.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/rand_pkg.sv
// Shared types and helpers for the multi-channel noise generator.
// The LFSR step function is also used by the reference model.
package rand_pkg;

   typedef enum logic [1:0] {
      MODE_UNI   = 2'd0,
      MODE_GAUSS = 2'd1,
      MODE_DC    = 2'd2,
      MODE_OFF   = 2'd3
   } mode_e;

   typedef enum logic [1:0] {
      ST_LOAD,
      ST_WARM,
      ST_FILL,
      ST_RUN
   } state_e;

   localparam int TAP_A = 63;
   localparam int TAP_B = 62;
   localparam int TAP_C = 60;
   localparam int TAP_D = 59;
   localparam int MAX_STEPS = 16;

   typedef logic signed [47:0] wide_t;

   // XNOR Fibonacci LFSR, shifts left, feedback enters at bit 0
   function automatic logic [63:0] lfsr_step(input logic [63:0] s,
                                             input int n);
      logic [63:0] r;
      r = s;
      for (int i = 0; i < MAX_STEPS; i++) begin
         if (i < n)
            r = {r[62:0], ~(r[TAP_A] ^ r[TAP_B] ^ r[TAP_C] ^ r[TAP_D])};
      end
      return r;
   endfunction

   function automatic wide_t sat(input wide_t x, input int w);
      wide_t hi;
      wide_t lo;
      hi = (wide_t'(1) <<< (w - 1)) - wide_t'(1);
      lo = -(wide_t'(1) <<< (w - 1));
      if (x > hi)
         return hi;
      else if (x < lo)
         return lo;
      return x;
   endfunction

endpackage

// File: rtl/rand_noise_ch.sv
// One noise channel: sequencing FSM, 64-bit LFSR and
// the four-stage shaping pipeline (distribution, gain, offset).
module rand_noise_ch
   import rand_pkg::*;
#(
   parameter int DW     = 14,
   parameter int WARMUP = 32,
   parameter int NSUM   = 4,
   parameter int CH     = 0
) (
   input  logic                 clk_i,
   input  logic                 rstn_i,
   input  logic                 init_i,
   input  logic [31:0]          seed_i,
   input  logic                 en_i,
   input  logic [1:0]           mode_i,
   input  logic [DW-1:0]        amp_i,
   input  logic signed [DW-1:0] offs_i,
   output logic signed [DW-1:0] dat_o,
   output logic                 dv_o,
   output logic                 busy_o
);

   localparam int SH = $clog2(NSUM) - 1;
   localparam int CW = $clog2(WARMUP + 4);

   state_e                  state;
   logic [CW-1:0]           cnt;
   logic [63:0]             lfsr;
   logic [63:0]             lnext;
   logic signed [DW-1:0]    s1, s2, s3, s4;
   logic signed [DW-1:0]    s2n, s3n, s4n;
   logic [NSUM-2:0][DW-1:0] hist;
   wide_t                   acc;
   wide_t                   prod;
   logic                    run;

   assign lnext = lfsr_step(lfsr, DW);

   always_comb begin
      acc = wide_t'(s1);
      for (int i = 0; i < NSUM - 1; i++)
         acc = acc + wide_t'(signed'(hist[i]));
   end

   always_comb begin
      s2n = '0;
      unique case (1'b1)
         (mode_i == MODE_UNI):   s2n = s1;
         (mode_i == MODE_GAUSS): s2n = DW'(sat(acc >>> SH, DW));
         default:                s2n = '0;
      endcase
      prod = wide_t'(s2) * wide_t'({1'b0, amp_i});
      s3n  = DW'(sat(prod >>> (DW - 1), DW));
      s4n  = '0;
      if (mode_i != MODE_OFF)
         s4n = DW'(sat(wide_t'(s3) + wide_t'(offs_i), DW));
   end

   always_ff @(posedge clk_i) begin
      if (!rstn_i) begin
         state <= ST_LOAD;
         cnt   <= '0;
         lfsr  <= '0;
         hist  <= '0;
         s1    <= '0;
         s2    <= '0;
         s3    <= '0;
         s4    <= '0;
      end else if (init_i) begin
         state <= ST_LOAD;
      end else if (state == ST_LOAD) begin
         // channel index in the upper word keeps lock-up unreachable
         state <= ST_WARM;
         cnt   <= '0;
         lfsr  <= {32'(CH), seed_i};
         hist  <= '0;
         s1    <= '0;
         s2    <= '0;
         s3    <= '0;
         s4    <= '0;
      end else if (en_i) begin
         lfsr <= lnext;
         s1   <= lnext[63 -: DW];
         for (int i = NSUM - 2; i > 0; i--)
            hist[i] <= hist[i-1];
         hist[0] <= s1;
         s2 <= s2n;
         s3 <= s3n;
         s4 <= s4n;
         unique case (state)
            ST_WARM: begin
               if (cnt == CW'(WARMUP - 1)) begin
                  state <= ST_FILL;
                  cnt   <= '0;
               end else begin
                  cnt <= cnt + CW'(1);
               end
            end
            ST_FILL: begin
               if (cnt == CW'(3)) begin
                  state <= ST_RUN;
                  cnt   <= '0;
               end else begin
                  cnt <= cnt + CW'(1);
               end
            end
            default: ;
         endcase
      end
   end

   assign run    = (state == ST_RUN);
   assign dat_o  = run ? s4 : '0;
   assign dv_o   = run & en_i;
   assign busy_o = ~run;

endmodule

// File: rtl/rand_noise_gen.sv
// Multi-channel pseudo-random noise source; one channel
// instance per output, the top only slices the buses.
module rand_noise_gen
   import rand_pkg::*;
#(
   parameter int DW     = 14,
   parameter int NCH    = 2,
   parameter int WARMUP = 32,
   parameter int NSUM   = 4
) (
   input  logic              clk_i,
   input  logic              rstn_i,
   input  logic [NCH-1:0]    init_i,
   input  logic [32*NCH-1:0] seed_i,
   input  logic [NCH-1:0]    en_i,
   input  logic [2*NCH-1:0]  mode_i,
   input  logic [DW*NCH-1:0] amp_i,
   input  logic [DW*NCH-1:0] offs_i,
   output logic [DW*NCH-1:0] dat_o,
   output logic [NCH-1:0]    dv_o,
   output logic [NCH-1:0]    busy_o
);

   for (genvar c = 0; c < NCH; c++) begin : g_ch
      rand_noise_ch #(
         .DW     (DW),
         .WARMUP (WARMUP),
         .NSUM   (NSUM),
         .CH     (c)
      ) u_ch (
         .clk_i  (clk_i),
         .rstn_i (rstn_i),
         .init_i (init_i[c]),
         .seed_i (seed_i[32*c +: 32]),
         .en_i   (en_i[c]),
         .mode_i (mode_i[2*c +: 2]),
         .amp_i  (amp_i[DW*c +: DW]),
         .offs_i (offs_i[DW*c +: DW]),
         .dat_o  (dat_o[DW*c +: DW]),
         .dv_o   (dv_o[c]),
         .busy_o (busy_o[c])
      );
   end

endmodule

// File: tb/tb_rand_noise_gen.sv
// Directed bench for rand_noise_gen: a sample-level reference
// model per channel checked against every valid output.
module tb_rand_noise_gen;
   import rand_pkg::*;

   logic        clk = 1'b0;
   logic        rstn;
   logic [1:0]  init;
   logic [1:0]  en;
   logic [63:0] seed;
   logic [3:0]  mode;
   logic [27:0] amp;
   logic [27:0] offs;
   logic [27:0] dat;
   logic [1:0]  dv;
   logic [1:0]  busy;

   int          cm[2];
   int          ca[2];
   int          co[2];
   logic [31:0] sd[2];

   logic [63:0] ml[2];
   int          mh[2][4];
   bit          mrun[2];

   int nvec = 0;
   int nbad = 0;

   always #5 clk = ~clk;

   assign seed = {sd[1], sd[0]};
   assign mode = {2'(cm[1]), 2'(cm[0])};
   assign amp  = {14'(ca[1]), 14'(ca[0])};
   assign offs = {14'(co[1]), 14'(co[0])};

   rand_noise_gen #(
      .DW     (14),
      .NCH    (2),
      .WARMUP (32),
      .NSUM   (4)
   ) dut (
      .clk_i  (clk),
      .rstn_i (rstn),
      .init_i (init),
      .seed_i (seed),
      .en_i   (en),
      .mode_i (mode),
      .amp_i  (amp),
      .offs_i (offs),
      .dat_o  (dat),
      .dv_o   (dv),
      .busy_o (busy)
   );

   task automatic chk(input string tag, input int got, input int exp);
      nvec++;
      if (got != exp) begin
         nbad++;
         $display("FAIL %s: got %0d, want %0d", tag, got, exp);
      end
   endtask

   function automatic int clamp(input int x);
      if (x > 8191) return 8191;
      if (x < -8192) return -8192;
      return x;
   endfunction

   function automatic int m_out(input int c);
      int s2;
      int s3;
      case (cm[c])
         0:       s2 = mh[c][0];
         1:       s2 = clamp((mh[c][0] + mh[c][1] + mh[c][2] + mh[c][3]) >>> 1);
         default: s2 = 0;
      endcase
      s3 = clamp((s2 * ca[c]) >>> 13);
      if (cm[c] == 3) return 0;
      return clamp(s3 + co[c]);
   endfunction

   task automatic m_step(input int c);
      ml[c] = lfsr_step(ml[c], 14);
      mh[c][3] = mh[c][2];
      mh[c][2] = mh[c][1];
      mh[c][1] = mh[c][0];
      mh[c][0] = int'($signed(ml[c][63:50]));
   endtask

   // model state at the first valid sample: 33 steps after load
   task automatic m_init(input int c);
      ml[c] = {32'(c), sd[c]};
      for (int k = 0; k < 4; k++) mh[c][k] = 0;
      repeat (33) m_step(c);
   endtask

   function automatic int dat_of(input int c);
      return int'($signed(dat[14*c +: 14]));
   endfunction

   task automatic adv();
      @(posedge clk);
      #1;
      for (int c = 0; c < 2; c++)
         if (mrun[c] && en[c]) m_step(c);
   endtask

   task automatic cmp();
      for (int c = 0; c < 2; c++) begin
         if (mrun[c]) begin
            chk($sformatf("dat%0d", c), dat_of(c), m_out(c));
            chk($sformatf("dv%0d", c), int'(dv[c]), int'(en[c]));
         end
      end
   endtask

   task automatic run(input int n);
      repeat (n) begin
         adv();
         cmp();
      end
   endtask

   task automatic skip(input int n);
      repeat (n) adv();
   endtask

   task automatic pulse(input logic [1:0] mask);
      for (int c = 0; c < 2; c++)
         if (mask[c]) mrun[c] = 1'b0;
      init = mask;
      adv();
      init = 2'b00;
   endtask

   task automatic start(input logic [1:0] mask);
      int n;
      pulse(mask);
      n = 0;
      while (((dv & mask) != mask) && n < 100) begin
         adv();
         n++;
         if (n == 20) chk("busy_warm", int'(busy & mask), int'(mask));
      end
      chk("latency", n, 37);
      for (int c = 0; c < 2; c++) begin
         if (mask[c]) begin
            m_init(c);
            mrun[c] = 1'b1;
         end
      end
      cmp();
   endtask

   initial begin
      int diff;
      int hits;
      int chg;
      int prev;
      rstn = 1'b0;
      init = 2'b00;
      en   = 2'b11;
      for (int c = 0; c < 2; c++) begin
         sd[c]   = 32'h1234_5678;
         cm[c]   = 0;
         ca[c]   = 32'h2000;
         co[c]   = 0;
         mrun[c] = 1'b0;
      end
      repeat (3) adv();
      chk("rst_dv", int'(dv), 0);
      chk("rst_dat", int'(dat), 0);
      chk("rst_busy", int'(busy), 3);
      rstn = 1'b1;
      skip(5);

      // equal seeds on both channels, unity gain uniform
      start(2'b11);
      diff = 0;
      repeat (300) begin
         adv();
         cmp();
         if (dat_of(0) != dat_of(1)) diff++;
      end
      chk("decorrelated", int'(diff > 250), 1);

      // freeze ch0 mid-run, ch1 keeps going
      en = 2'b10;
      run(50);
      en = 2'b11;
      run(200);

      // high gain plus offset drives into clipping
      for (int c = 0; c < 2; c++) begin
         ca[c] = 16383;
         co[c] = 8191;
      end
      skip(4);
      hits = 0;
      repeat (300) begin
         adv();
         cmp();
         if (dat_of(0) == 8191) hits++;
      end
      chk("clip_seen", int'(hits > 0), 1);

      for (int c = 0; c < 2; c++) ca[c] = 0;
      skip(4);
      run(20);
      chk("amp0", dat_of(0), 8191);

      // approx-Gaussian
      for (int c = 0; c < 2; c++) begin
         cm[c] = 1;
         ca[c] = 32'h2000;
         co[c] = 0;
      end
      skip(4);
      run(500);

      // DC then off
      for (int c = 0; c < 2; c++) begin
         cm[c] = 2;
         co[c] = -100;
      end
      skip(4);
      run(20);
      chk("dc", dat_of(1), -100);
      for (int c = 0; c < 2; c++) cm[c] = 3;
      skip(4);
      run(20);
      chk("off_dat", dat_of(0), 0);
      chk("off_dv", int'(dv[0]), 1);

      for (int c = 0; c < 2; c++) begin
         cm[c] = 0;
         co[c] = 0;
      end
      skip(4);

      // reseed mid-run, then mid-warmup
      start(2'b01);
      run(200);
      pulse(2'b01);
      skip(10);
      start(2'b01);
      run(200);

      // extreme seeds must not lock up
      sd[0] = 32'hFFFF_FFFF;
      sd[1] = 32'h0000_0000;
      start(2'b11);
      chg  = 0;
      prev = dat_of(0);
      repeat (500) begin
         adv();
         cmp();
         if (dat_of(0) != prev) chg++;
         prev = dat_of(0);
      end
      chk("no_lockup", int'(chg > 400), 1);

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nbad);
      $finish;
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got timeout, want finish");
      $fatal(1, "watchdog");
   end

endmodule
